// File: rtl/sha3_pad_absorb_if.sv
// Message-in / block-out bus for sha3_pad_absorb. The xof input exists only when
// SHA3_PAD_XOF_EN is defined.
interface sha3_pad_absorb_if #(
  parameter int unsigned RATE_LANES = 17
);
  logic                       in_valid;
  logic                       in_ready;
  logic [63:0]                in_data;
  logic                       in_last;
  logic [3:0]                 in_nbytes;
  logic                       blk_valid;
  logic                       blk_ready;
  logic [RATE_LANES*64-1:0]   blk_lanes;
  logic                       blk_last;
`ifdef SHA3_PAD_XOF_EN
  logic                       xof;
`endif

  modport master (
    output in_valid, in_data, in_last, in_nbytes, blk_ready,
`ifdef SHA3_PAD_XOF_EN
    output xof,
`endif
    input  in_ready, blk_valid, blk_lanes, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, blk_ready,
`ifdef SHA3_PAD_XOF_EN
    input  xof,
`endif
    output in_ready, blk_valid, blk_lanes, blk_last
  );
endinterface

// File: rtl/sha3_pad_absorb.sv
// SHA-3 pad10*1 + domain-byte padding and rate-block assembly ahead of Keccak-f[1600].
// Define SHA3_PAD_XOF_EN to add the xof input that selects the SHAKE domain byte 8'h1F.
module sha3_pad_absorb #(
  parameter int unsigned RATE_LANES = 17,
  parameter logic [7:0]  DS         = 8'h06
) (
  input logic               clk,
  input logic               rst,
  sha3_pad_absorb_if.slave  bus
);
  localparam int unsigned CntW = $clog2(RATE_LANES);

  typedef enum logic [1:0] {StFill, StEmit, StExtra} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] lane_cnt_q, lane_cnt_d;
  logic [63:0]     lanes_q [RATE_LANES];
  logic [63:0]     lanes_d [RATE_LANES];
  logic            blk_last_q, blk_last_d;
  logic            extra_pend_q, extra_pend_d;
  logic [3:0]      nb;
  logic [7:0]      dom_in;
  logic [7:0]      dom_extra;
  int unsigned     cnt;

  assign cnt = 32'(lane_cnt_q);
  assign nb  = (bus.in_nbytes > 4'd8) ? 4'd8 : bus.in_nbytes;

`ifdef SHA3_PAD_XOF_EN
  logic [7:0] dom_q, dom_d;
  assign dom_in    = bus.xof ? 8'h1F : DS;
  assign dom_extra = dom_q;
`else
  assign dom_in    = DS;
  assign dom_extra = DS;
`endif

  // Keep bytes below n, place the domain byte at n, zero the rest.
  function automatic logic [63:0] pad_word(logic [63:0] d, logic [3:0] n, logic [7:0] dom);
    logic [63:0] w;
    w = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < 32'(n))       w[8*b +: 8] = d[8*b +: 8];
      else if (b == 32'(n)) w[8*b +: 8] = dom;
    end
    return w;
  endfunction

  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    lanes_d      = lanes_q;
    blk_last_d   = blk_last_q;
    extra_pend_d = extra_pend_q;
`ifdef SHA3_PAD_XOF_EN
    dom_d        = dom_q;
`endif
    unique case (state_q)
      StFill: begin
        if (bus.in_valid) begin
          if (!bus.in_last) begin
            lanes_d[lane_cnt_q] = bus.in_data;
            if (lane_cnt_q == CntW'(RATE_LANES - 1)) begin
              lane_cnt_d = '0;
              blk_last_d = 1'b0;
              state_d    = StEmit;
            end else begin
              lane_cnt_d = lane_cnt_q + 1'b1;
            end
          end else begin
            lane_cnt_d = '0;
            state_d    = StEmit;
            if (lane_cnt_q == CntW'(RATE_LANES - 1) && nb == 4'd8) begin
              // Full final lane: padding needs a whole extra block.
              lanes_d[lane_cnt_q] = bus.in_data;
              blk_last_d          = 1'b0;
              extra_pend_d        = 1'b1;
`ifdef SHA3_PAD_XOF_EN
              dom_d               = dom_in;
`endif
            end else begin
              for (int unsigned i = 0; i < RATE_LANES; i++) begin
                if (i == cnt) begin
                  lanes_d[i] = pad_word(bus.in_data, nb, dom_in);
                end else if (i > cnt) begin
                  lanes_d[i] = (i == cnt + 1 && nb == 4'd8) ? {56'h0, dom_in} : 64'h0;
                end
              end
              lanes_d[RATE_LANES-1][63:56] = lanes_d[RATE_LANES-1][63:56] | 8'h80;
              blk_last_d = 1'b1;
            end
          end
        end
      end
      StEmit: begin
        if (bus.blk_ready) begin
          blk_last_d = 1'b0;
          state_d    = extra_pend_q ? StExtra : StFill;
        end
      end
      StExtra: begin
        for (int unsigned i = 0; i < RATE_LANES; i++) lanes_d[i] = 64'h0;
        lanes_d[0]            = {56'h0, dom_extra};
        lanes_d[RATE_LANES-1] = {8'h80, 56'h0};
        blk_last_d            = 1'b1;
        extra_pend_d          = 1'b0;
        state_d               = StEmit;
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFill;
      lane_cnt_q   <= '0;
      blk_last_q   <= 1'b0;
      extra_pend_q <= 1'b0;
      for (int unsigned i = 0; i < RATE_LANES; i++) lanes_q[i] <= 64'h0;
`ifdef SHA3_PAD_XOF_EN
      dom_q        <= DS;
`endif
    end else begin
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      blk_last_q   <= blk_last_d;
      extra_pend_q <= extra_pend_d;
      lanes_q      <= lanes_d;
`ifdef SHA3_PAD_XOF_EN
      dom_q        <= dom_d;
`endif
    end
  end

  // rst gates in_ready so every output reads 0 while reset is held.
  assign bus.in_ready  = (state_q == StFill) && !rst;
  assign bus.blk_valid = (state_q == StEmit);
  assign bus.blk_last  = blk_last_q;

  // Lane storage doubles as the fill buffer, so only expose it while emitting.
  always_comb begin
    bus.blk_lanes = '0;
    for (int unsigned i = 0; i < RATE_LANES; i++) begin
      bus.blk_lanes[64*i +: 64] = (state_q == StEmit) ? lanes_q[i] : 64'h0;
    end
  end
endmodule

// File: tb/tb_sha3_pad_absorb.sv
// Randomised bench for sha3_pad_absorb against a byte-level SHA-3 padding model.
module tb_sha3_pad_absorb;
  localparam int unsigned RL = 17;
  localparam logic [7:0]  DS = 8'h06;
  localparam int          RB = RL * 8;

  logic clk = 1'b0;
  logic rst;
  logic cur_xof;

  sha3_pad_absorb_if #(.RATE_LANES(RL)) bus ();
  sha3_pad_absorb #(.RATE_LANES(RL), .DS(DS)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [RL*64-1:0] lanes;
    logic             last;
    logic             pad_next;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] msg[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         hold     = 0;
  bit         force_rdy = 0;

  task automatic check_eq(input string tag, input logic [RL*64-1:0] got,
                          input logic [RL*64-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte-level padding: msg || dom || 0* with 0x80 ORed into the final rate byte.
  function automatic void push_expected(int len, int nlast, logic [7:0] dom);
    logic [7:0] p[$];
    int nblk;
    p = msg;
    p.push_back(dom);
    while (p.size() % RB != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nblk = p.size() / RB;
    for (int j = 0; j < nblk; j++) begin
      exp_t e;
      for (int b = 0; b < RB; b++) e.lanes[8*b +: 8] = p[j*RB + b];
      e.last     = (j == nblk - 1);
      e.pad_next = (j == nblk - 2) && (nlast == 8) && (len % RB == 0);
      exp_q.push_back(e);
    end
  endfunction

  task automatic fill_random(input int len);
    msg.delete();
    repeat (len) msg.push_back(8'($urandom));
  endtask

  // Called just after a negedge; returns just after the negedge following the handshake.
  task automatic drive_word(input logic [63:0] d, input logic last, input logic [3:0] nbytes,
                            input bit completes);
    int guard = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_last   = last;
    bus.in_nbytes = nbytes;
`ifdef SHA3_PAD_XOF_EN
    bus.xof       = cur_xof;
`endif
    while (!bus.in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check_eq("in_ready_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (completes) check_eq("blk_valid_latency", bus.blk_valid, 1);
  endtask

  task automatic send_msg(input int len, input int nlast);
    int         k;
    logic [7:0] dom;
    k = (len - nlast) / 8;
`ifdef SHA3_PAD_XOF_EN
    cur_xof = 1'($urandom);
    dom     = cur_xof ? 8'h1F : DS;
`else
    cur_xof = 1'b0;
    dom     = DS;
`endif
    push_expected(len, nlast, dom);
    for (int w = 0; w <= k; w++) begin
      logic [63:0] d;
      logic [3:0]  nb;
      int          nv;
      repeat ($urandom % 3) @(negedge clk);
      nv = (w < k) ? 8 : nlast;
      for (int b = 0; b < 8; b++) d[8*b +: 8] = (b < nv) ? msg[8*w + b] : 8'($urandom);
      if (w < k)                                 nb = 4'($urandom);
      else if (nlast == 8 && $urandom % 4 == 0) nb = 4'(9 + $urandom % 7);
      else                                       nb = 4'(nlast);
      drive_word(d, w == k, nb, (w == k) || (w % RL == RL - 1));
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Block consumer: random backpressure, scoreboard and protocol checks.
  initial begin
    logic [RL*64-1:0] prev_lanes;
    logic             prev_last;
    bit               prev_stall = 0;
    bit               chk_ir     = 0;
    bit               exp_ir     = 0;
    bit               r;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        chk_ir     = 0;
        continue;
      end
      if (chk_ir) begin
        check_eq("in_ready_after_blk", bus.in_ready, exp_ir);
        chk_ir = 0;
      end
      if (bus.blk_valid) begin
        check_eq("in_ready_in_emit", bus.in_ready, 0);
        if (prev_stall) begin
          check_eq("stall_lanes", bus.blk_lanes, prev_lanes);
          check_eq("stall_last", bus.blk_last, prev_last);
        end
        if (hold > 0) begin
          r = 0;
          hold--;
          if (hold == 0) force_rdy = 1;
        end else if (force_rdy) begin
          r = 1;
          force_rdy = 0;
        end else begin
          r = ($urandom % 4) != 0;
        end
        bus.blk_ready = r;
        if (r) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_blk", 1, 0);
          end else begin
            check_eq("blk_lanes", bus.blk_lanes, exp_q[0].lanes);
            check_eq("blk_last", bus.blk_last, exp_q[0].last);
            exp_ir = exp_q[0].last || !exp_q[0].pad_next;
            chk_ir = 1;
            void'(exp_q.pop_front());
          end
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_lanes = bus.blk_lanes;
          prev_last  = bus.blk_last;
        end
      end else begin
        bus.blk_ready = 1'($urandom);
        check_eq("idle_lanes_zero", bus.blk_lanes, 0);
        check_eq("idle_last_zero", bus.blk_last, 0);
        prev_stall = 0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_checks++;
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst           = 1'b1;
    cur_xof       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 64'h0;
    bus.in_last   = 1'b0;
    bus.in_nbytes = 4'h0;
    bus.blk_ready = 1'b0;
`ifdef SHA3_PAD_XOF_EN
    bus.xof       = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_blk_valid", bus.blk_valid, 0);
    check_eq("rst_blk_last", bus.blk_last, 0);
    check_eq("rst_blk_lanes", bus.blk_lanes, 0);
    rst = 1'b0;
    @(negedge clk);

    msg.delete();
    send_msg(0, 0);
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    send_msg(3, 3);
    fill_random(128);
    msg.push_back(8'h66); msg.push_back(8'h55); msg.push_back(8'h44); msg.push_back(8'h33);
    msg.push_back(8'h22); msg.push_back(8'h11); msg.push_back(8'h00);
    send_msg(135, 7);
    fill_random(136);
    send_msg(136, 8);
    fill_random(136);
    send_msg(136, 0);
    wait_drain();

    hold = 5;
    fill_random(20);
    send_msg(20, 4);
    wait_drain();

    // Reset in the middle of a message must leave no residue.
    fill_random(72);
    for (int w = 0; w < 9; w++) begin
      logic [63:0] d;
      for (int b = 0; b < 8; b++) d[8*b +: 8] = msg[8*w + b];
      drive_word(d, 1'b0, 4'h0, 1'b0);
    end
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_in_ready", bus.in_ready, 0);
    check_eq("midrst_blk_valid", bus.blk_valid, 0);
    check_eq("midrst_blk_last", bus.blk_last, 0);
    check_eq("midrst_blk_lanes", bus.blk_lanes, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    msg.delete();
    send_msg(0, 0);
    wait_drain();

    repeat (40) begin
      int nl;
      int k;
      nl = $urandom % 9;
      k  = $urandom % 40;
      fill_random(8 * k + nl);
      send_msg(8 * k + nl, nl);
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
